// File: rtl/mem_access_unit_if.sv
// Data-RAM request/acknowledge bus between the MEM-stage access unit (master) and RAM (slave).
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, bus_err,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, bus_err,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: word-aligned RAM requests, load extension, store strobes.
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ex_valid,
  input  logic                     ex_memRead,
  input  logic                     ex_memWrite,
  input  logic                     ex_memToReg,
  input  logic                     ex_regWrite,
  input  logic [2:0]               ex_funct3,
  input  logic [31:0]              ex_ALUResult,
  input  logic [31:0]              ex_storeData,
  input  logic [4:0]               ex_rd,
  output logic                     stall,
  output logic                     misaligned,
  output logic                     mem_memToReg,
  output logic                     mem_regWrite,
  output logic [31:0]              mem_dataFromRAM,
  output logic [31:0]              mem_ALUResult,
  output logic [4:0]               mem_rd,
  mem_access_unit_if.master        bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic        req_q, we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_off;
  logic [4:0]  lat_rd;
  logic [31:0] lat_alu, lat_data;
  logic        lat_regwrite, lat_memtoreg, lat_store;

  logic        memop, mis, start;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic        timeout_hit, aborted;

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b100:  load_extend = {24'd0, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b101:  load_extend = {16'd0, h};
      default: load_extend = w;
    endcase
  endfunction

  assign memop = ex_valid & (ex_memRead | ex_memWrite);
  assign mis   = ((ex_funct3[1:0] == 2'b01) & ex_ALUResult[0]) |
                 ((ex_funct3 == 3'b010) & (ex_ALUResult[1:0] != 2'b00));
  assign start = (state == S_IDLE) & memop & ~mis;

  always_comb begin
    st_wstrb = 4'b0000;
    st_wdata = ex_storeData;
    if (ex_memWrite) begin
      case (ex_funct3[1:0])
        2'b00: begin
          st_wstrb = 4'b0001 << ex_ALUResult[1:0];
          st_wdata = {4{ex_storeData[7:0]}};
        end
        2'b01: begin
          st_wstrb = 4'b0011 << {ex_ALUResult[1], 1'b0};
          st_wdata = {2{ex_storeData[15:0]}};
        end
        default: st_wstrb = 4'b1111;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      lat_funct3   <= '0;
      lat_off      <= '0;
      lat_rd       <= '0;
      lat_alu      <= '0;
      lat_data     <= '0;
      lat_regwrite <= 1'b0;
      lat_memtoreg <= 1'b0;
      lat_store    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state        <= S_BUSY;
          req_q        <= 1'b1;
          we_q         <= ex_memWrite;
          addr_q       <= {ex_ALUResult[31:2], 2'b00};
          wdata_q      <= st_wdata;
          wstrb_q      <= st_wstrb;
          lat_funct3   <= ex_funct3;
          lat_off      <= ex_ALUResult[1:0];
          lat_rd       <= ex_rd;
          lat_alu      <= ex_ALUResult;
          lat_regwrite <= ex_regWrite;
          lat_memtoreg <= ex_memToReg;
          lat_store    <= ex_memWrite;
        end
        S_BUSY: if (bus.bus_ack) begin
          req_q    <= 1'b0;
          lat_data <= lat_store ? 32'd0 : load_extend(lat_funct3, lat_off, bus.bus_rdata);
          state    <= S_DONE;
        end else if (timeout_hit) begin
          req_q    <= 1'b0;
          lat_data <= 32'd0;
          state    <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] wd_cnt;
  logic       err_q, abort_q;

  // The last permitted BUSY cycle without ack aborts the access.
  assign timeout_hit = (state == S_BUSY) & ~bus.bus_ack & (wd_cnt == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt  <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      err_q  <= timeout_hit;
      wd_cnt <= (state == S_BUSY) ? wd_cnt + 8'd1 : 8'd0;
      if (start)
        abort_q <= 1'b0;
      else if (timeout_hit)
        abort_q <= 1'b1;
    end
  end

  assign aborted     = abort_q;
  assign bus.bus_err = err_q;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
  assign timeout_hit        = 1'b0;
  assign aborted            = 1'b0;
  assign bus.bus_err        = 1'b0;
`endif

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_wstrb = wstrb_q;

  // MEM/WB has no enable, so every stalled cycle must present a bubble.
  always_comb begin
    stall           = 1'b0;
    misaligned      = 1'b0;
    mem_memToReg    = 1'b0;
    mem_regWrite    = 1'b0;
    mem_dataFromRAM = 32'd0;
    mem_ALUResult   = 32'd0;
    mem_rd          = 5'd0;
    case (state)
      S_IDLE: begin
        if (start) begin
          stall = 1'b1;
        end else begin
          misaligned    = memop & mis;
          mem_memToReg  = ex_valid & ex_memToReg & ~memop;
          mem_regWrite  = ex_valid & ex_regWrite & ~memop;
          mem_ALUResult = ex_ALUResult;
          mem_rd        = ex_rd;
        end
      end
      S_BUSY: stall = 1'b1;
      S_DONE: begin
        mem_memToReg    = lat_memtoreg;
        mem_regWrite    = lat_regwrite & ~lat_store & ~aborted;
        mem_dataFromRAM = lat_data;
        mem_ALUResult   = lat_alu;
        mem_rd          = lat_rd;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (watchdog scenario only when MEM_TIMEOUT_EN is defined).
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid, ex_memRead, ex_memWrite, ex_memToReg, ex_regWrite;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_ALUResult, ex_storeData;
  logic [4:0]  ex_rd;
  logic        stall, misaligned, mem_memToReg, mem_regWrite;
  logic [31:0] mem_dataFromRAM, mem_ALUResult;
  logic [4:0]  mem_rd;
  int          n_cmp = 0;
  int          n_bad = 0;

  typedef struct packed {
    logic [2:0]  f3;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
  } vec_t;

  mem_access_unit_if bus_if ();

  mem_access_unit #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
    .ex_memToReg(ex_memToReg), .ex_regWrite(ex_regWrite), .ex_funct3(ex_funct3),
    .ex_ALUResult(ex_ALUResult), .ex_storeData(ex_storeData), .ex_rd(ex_rd),
    .stall(stall), .misaligned(misaligned),
    .mem_memToReg(mem_memToReg), .mem_regWrite(mem_regWrite),
    .mem_dataFromRAM(mem_dataFromRAM), .mem_ALUResult(mem_ALUResult), .mem_rd(mem_rd),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_memRead = 0; ex_memWrite = 0; ex_memToReg = 0; ex_regWrite = 0;
    ex_funct3 = 3'd0; ex_ALUResult = 32'd0; ex_storeData = 32'd0; ex_rd = 5'd0;
  endtask

  task automatic test_reset();
    clear_ex();
    bus_if.bus_ack = 0; bus_if.bus_rdata = 32'd0;
    #12;
    n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", bus_if.bus_req); end
    n_cmp++; if (bus_if.bus_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", bus_if.bus_we); end
    n_cmp++; if (bus_if.bus_addr !== 32'd0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", bus_if.bus_addr); end
    n_cmp++; if (bus_if.bus_wdata !== 32'd0) begin n_bad++; $display("FAIL reset_wdata: got %h want 0", bus_if.bus_wdata); end
    n_cmp++; if (bus_if.bus_wstrb !== 4'd0) begin n_bad++; $display("FAIL reset_wstrb: got %b want 0", bus_if.bus_wstrb); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_cmp++; if (bus_if.bus_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus_if.bus_err); end
    rst = 0;
  endtask

  task automatic test_alu();
    tick();
    ex_valid = 1; ex_regWrite = 1; ex_rd = 5'd5; ex_ALUResult = 32'h1234;
    #1;
    n_cmp++; if (mem_regWrite !== 1'b1) begin n_bad++; $display("FAIL alu_regwrite: got %b want 1", mem_regWrite); end
    n_cmp++; if (mem_rd !== 5'd5) begin n_bad++; $display("FAIL alu_rd: got %0d want 5", mem_rd); end
    n_cmp++; if (mem_ALUResult !== 32'h1234) begin n_bad++; $display("FAIL alu_result: got %h want 1234", mem_ALUResult); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL alu_stall: got %b want 0", stall); end
    n_cmp++; if (mem_dataFromRAM !== 32'd0) begin n_bad++; $display("FAIL alu_data: got %h want 0", mem_dataFromRAM); end
    tick();
    n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_bad++; $display("FAIL alu_req: got %b want 0", bus_if.bus_req); end
    clear_ex();
  endtask

  task automatic test_lb();
    tick();
    ex_valid = 1; ex_memRead = 1; ex_memToReg = 1; ex_regWrite = 1;
    ex_funct3 = 3'b000; ex_ALUResult = 32'h103; ex_rd = 5'd7;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin bus_if.bus_ack = 1; bus_if.bus_rdata = 32'h80FF_0000; end
      #1;
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lb_stall c%0d: got %b want 1", c, stall); end
      n_cmp++; if (mem_regWrite !== 1'b0 || mem_rd !== 5'd0) begin n_bad++; $display("FAIL lb_bubble c%0d: got rw=%b rd=%0d want 0/0", c, mem_regWrite, mem_rd); end
      if (c > 0) begin
        n_cmp++; if (bus_if.bus_req !== 1'b1) begin n_bad++; $display("FAIL lb_req c%0d: got %b want 1", c, bus_if.bus_req); end
        n_cmp++; if (bus_if.bus_addr !== 32'h100) begin n_bad++; $display("FAIL lb_addr c%0d: got %h want 100", c, bus_if.bus_addr); end
        n_cmp++; if (bus_if.bus_wstrb !== 4'd0) begin n_bad++; $display("FAIL lb_wstrb c%0d: got %b want 0", c, bus_if.bus_wstrb); end
      end
      tick();
    end
    bus_if.bus_ack = 0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lb_done_stall: got %b want 0", stall); end
    n_cmp++; if (mem_dataFromRAM !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_data: got %h want ffffff80", mem_dataFromRAM); end
    n_cmp++; if (mem_regWrite !== 1'b1) begin n_bad++; $display("FAIL lb_regwrite: got %b want 1", mem_regWrite); end
    n_cmp++; if (mem_rd !== 5'd7) begin n_bad++; $display("FAIL lb_rd: got %0d want 7", mem_rd); end
    n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_bad++; $display("FAIL lb_req_drop: got %b want 0", bus_if.bus_req); end
    clear_ex();
  endtask

  task automatic test_sh();
    tick();
    ex_valid = 1; ex_memWrite = 1; ex_regWrite = 1; ex_funct3 = 3'b001;
    ex_ALUResult = 32'h202; ex_storeData = 32'h0000_ABCD; ex_rd = 5'd2;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL sh_stall0: got %b want 1", stall); end
    tick();
    n_cmp++; if (bus_if.bus_we !== 1'b1) begin n_bad++; $display("FAIL sh_we: got %b want 1", bus_if.bus_we); end
    n_cmp++; if (bus_if.bus_addr !== 32'h200) begin n_bad++; $display("FAIL sh_addr: got %h want 200", bus_if.bus_addr); end
    n_cmp++; if (bus_if.bus_wstrb !== 4'b1100) begin n_bad++; $display("FAIL sh_wstrb: got %b want 1100", bus_if.bus_wstrb); end
    n_cmp++; if (bus_if.bus_wdata !== 32'hABCD_ABCD) begin n_bad++; $display("FAIL sh_wdata: got %h want abcdabcd", bus_if.bus_wdata); end
    bus_if.bus_ack = 1;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL sh_stall1: got %b want 1", stall); end
    tick();
    bus_if.bus_ack = 0;
    #1;
    n_cmp++; if (mem_regWrite !== 1'b0) begin n_bad++; $display("FAIL sh_regwrite: got %b want 0", mem_regWrite); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL sh_done_stall: got %b want 0", stall); end
    n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_bad++; $display("FAIL sh_req_drop: got %b want 0", bus_if.bus_req); end
    clear_ex();
  endtask

  task automatic test_misaligned();
    tick();
    ex_valid = 1; ex_memRead = 1; ex_memToReg = 1; ex_regWrite = 1;
    ex_funct3 = 3'b010; ex_ALUResult = 32'h101; ex_rd = 5'd4;
    #1;
    n_cmp++; if (misaligned !== 1'b1) begin n_bad++; $display("FAIL mis_flag: got %b want 1", misaligned); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL mis_stall: got %b want 0", stall); end
    n_cmp++; if (mem_regWrite !== 1'b0 || mem_memToReg !== 1'b0) begin n_bad++; $display("FAIL mis_ctrl: got rw=%b m2r=%b want 0/0", mem_regWrite, mem_memToReg); end
    tick();
    clear_ex();
    #1;
    n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_bad++; $display("FAIL mis_req: got %b want 0", bus_if.bus_req); end
    n_cmp++; if (misaligned !== 1'b0) begin n_bad++; $display("FAIL mis_one_cycle: got %b want 0", misaligned); end
  endtask

  task automatic test_table();
    vec_t v[6];
    v[0] = '{3'b100, 1'b1, 1'b0, 32'h101, 32'h0, 32'h1234_5678, 32'h0000_0056, 4'b0000, 32'h0};
    v[1] = '{3'b001, 1'b1, 1'b0, 32'h102, 32'h0, 32'h8001_1234, 32'hFFFF_8001, 4'b0000, 32'h0};
    v[2] = '{3'b010, 1'b1, 1'b0, 32'h104, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b0000, 32'h0};
    v[3] = '{3'b000, 1'b0, 1'b1, 32'h101, 32'h0000_00A5, 32'h0, 32'h0, 4'b0010, 32'hA5A5_A5A5};
    v[4] = '{3'b010, 1'b1, 1'b1, 32'h108, 32'h1122_3344, 32'h0, 32'h0, 4'b1111, 32'h1122_3344};
    v[5] = '{3'b000, 1'b1, 1'b0, 32'h200, 32'h0, 32'hFFFF_FF7F, 32'h0000_007F, 4'b0000, 32'h0};
    for (int i = 0; i < 6; i++) begin
      tick();
      ex_valid = 1; ex_memRead = v[i].rd_en; ex_memWrite = v[i].wr_en;
      ex_memToReg = v[i].rd_en & ~v[i].wr_en; ex_regWrite = 1; ex_funct3 = v[i].f3;
      ex_ALUResult = v[i].addr; ex_storeData = v[i].sdata; ex_rd = 5'(10 + i);
      #1;
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL tbl%0d_stall: got %b want 1", i, stall); end
      tick();
      n_cmp++; if (bus_if.bus_we !== v[i].wr_en) begin n_bad++; $display("FAIL tbl%0d_we: got %b want %b", i, bus_if.bus_we, v[i].wr_en); end
      n_cmp++; if (bus_if.bus_addr !== {v[i].addr[31:2], 2'b00}) begin n_bad++; $display("FAIL tbl%0d_addr: got %h want %h", i, bus_if.bus_addr, {v[i].addr[31:2], 2'b00}); end
      n_cmp++; if (bus_if.bus_wstrb !== v[i].exp_strb) begin n_bad++; $display("FAIL tbl%0d_wstrb: got %b want %b", i, bus_if.bus_wstrb, v[i].exp_strb); end
      if (v[i].wr_en) begin
        n_cmp++; if (bus_if.bus_wdata !== v[i].exp_wdata) begin n_bad++; $display("FAIL tbl%0d_wdata: got %h want %h", i, bus_if.bus_wdata, v[i].exp_wdata); end
      end
      bus_if.bus_ack = 1; bus_if.bus_rdata = v[i].rdata;
      tick();
      bus_if.bus_ack = 0;
      #1;
      n_cmp++; if (mem_regWrite !== ~v[i].wr_en) begin n_bad++; $display("FAIL tbl%0d_regwrite: got %b want %b", i, mem_regWrite, ~v[i].wr_en); end
      n_cmp++; if (mem_rd !== 5'(10 + i)) begin n_bad++; $display("FAIL tbl%0d_rd: got %0d want %0d", i, mem_rd, 10 + i); end
      if (!v[i].wr_en) begin
        n_cmp++; if (mem_dataFromRAM !== v[i].exp_data) begin n_bad++; $display("FAIL tbl%0d_data: got %h want %h", i, mem_dataFromRAM, v[i].exp_data); end
      end
      clear_ex();
    end
  endtask

  task automatic test_reset_mid();
    tick();
    ex_valid = 1; ex_memRead = 1; ex_memToReg = 1; ex_regWrite = 1;
    ex_funct3 = 3'b010; ex_ALUResult = 32'h10; ex_rd = 5'd8;
    tick();
    n_cmp++; if (bus_if.bus_req !== 1'b1) begin n_bad++; $display("FAIL rmid_req_busy: got %b want 1", bus_if.bus_req); end
    #2;
    rst = 1;
    clear_ex();
    #1;
    n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_bad++; $display("FAIL rmid_req_async: got %b want 0", bus_if.bus_req); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rmid_stall: got %b want 0", stall); end
    tick();
    rst = 0;
    tick();
    bus_if.bus_ack = 1; bus_if.bus_rdata = 32'hFFFF_FFFF;
    ex_valid = 1; ex_regWrite = 1; ex_rd = 5'd9; ex_ALUResult = 32'h55;
    #1;
    n_cmp++; if (mem_rd !== 5'd9 || mem_regWrite !== 1'b1) begin n_bad++; $display("FAIL rmid_idle_pass: got rd=%0d rw=%b want 9/1", mem_rd, mem_regWrite); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rmid_late_ack_stall: got %b want 0", stall); end
    tick();
    bus_if.bus_ack = 0;
    clear_ex();
    #1;
    n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_bad++; $display("FAIL rmid_late_ack_req: got %b want 0", bus_if.bus_req); end
    n_cmp++; if (mem_ALUResult !== 32'd0 || mem_regWrite !== 1'b0) begin n_bad++; $display("FAIL rmid_no_done: got alu=%h rw=%b want 0/0", mem_ALUResult, mem_regWrite); end
    tick();
    ex_valid = 1; ex_memRead = 1; ex_memToReg = 1; ex_regWrite = 1;
    ex_funct3 = 3'b101; ex_ALUResult = 32'h002; ex_rd = 5'd3;
    tick();
    n_cmp++; if (bus_if.bus_addr !== 32'h0 || bus_if.bus_req !== 1'b1) begin n_bad++; $display("FAIL lhu_bus: got addr=%h req=%b want 0/1", bus_if.bus_addr, bus_if.bus_req); end
    bus_if.bus_ack = 1; bus_if.bus_rdata = 32'h8001_0000;
    tick();
    bus_if.bus_ack = 0;
    #1;
    n_cmp++; if (mem_dataFromRAM !== 32'h0000_8001) begin n_bad++; $display("FAIL lhu_data: got %h want 00008001", mem_dataFromRAM); end
    n_cmp++; if (mem_regWrite !== 1'b1 || mem_rd !== 5'd3) begin n_bad++; $display("FAIL lhu_wb: got rw=%b rd=%0d want 1/3", mem_regWrite, mem_rd); end
    clear_ex();
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    tick();
    ex_valid = 1; ex_memRead = 1; ex_memToReg = 1; ex_regWrite = 1;
    ex_funct3 = 3'b010; ex_ALUResult = 32'h20; ex_rd = 5'd6;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++; if (bus_if.bus_req !== 1'b1 || bus_if.bus_err !== 1'b0) begin n_bad++; $display("FAIL to_busy c%0d: got req=%b err=%b want 1/0", c, bus_if.bus_req, bus_if.bus_err); end
    end
    tick();
    n_cmp++; if (bus_if.bus_err !== 1'b1) begin n_bad++; $display("FAIL to_err: got %b want 1", bus_if.bus_err); end
    n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_bad++; $display("FAIL to_req: got %b want 0", bus_if.bus_req); end
    n_cmp++; if (mem_regWrite !== 1'b0 || stall !== 1'b0) begin n_bad++; $display("FAIL to_done: got rw=%b stall=%b want 0/0", mem_regWrite, stall); end
    clear_ex();
    tick();
    n_cmp++; if (bus_if.bus_err !== 1'b0) begin n_bad++; $display("FAIL to_err_pulse: got %b want 0", bus_if.bus_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_lb();
    test_sh();
    test_misaligned();
    test_table();
    test_reset_mid();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
